spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI serial block and consumes its received-byte stream (rx_data/rx_valid).
- Parses framed commands of the form [CMD][ADDR][DATA...] into writes and reads of a small 8-bit register bank.
- The register bank drives the nixie display and control logic.
- For reads, it returns bytes to the SPI block's transmit side through a valid/ready handshake.

Parameters:
- NUM_REGS, 8: number of 8-bit registers; must be a power of two, 2..256.
- ADDR_W, $clog2(NUM_REGS): register address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- frame_active  in  1  high while the SPI chip-select is asserted; delimits a frame.
- rx_data  in  8  received byte from the SPI block.
- rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle.
- tx_data  out  8  byte to transmit back to the master.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  SPI block accepts tx_data when tx_valid & tx_ready.
- regs_flat  out  NUM_REGS*8  register bank contents; reg i is bits [8i+7:8i].
- wr_strobe  out  NUM_REGS  one-hot, one-cycle pulse in the cycle a register updates.
- err_count  out  8  saturating count of rejected frames.

Behaviour:
- Reset (sync, rst=1): all registers 0x00, tx_data=0x00, tx_valid=0, wr_strobe=0, err_count=0, state=IDLE, addr pointer=0. Reset mid-frame aborts the frame; the frame is not resumed when rst deasserts.
- States: IDLE, CMD, ADDR, WDATA, RDATA, DISCARD.
- IDLE: frame_active=1 -> CMD on the next cycle. rx_valid is ignored in IDLE.
- CMD: on rx_valid:
  - 0x01 (CMD_WRITE) -> ADDR, mode write.
  - 0x02 (CMD_READ) -> ADDR, mode read.
  - Any other value -> DISCARD, err_count+1.
- ADDR: on rx_valid:
  - rx_data >= NUM_REGS -> DISCARD, err_count+1.
  - Otherwise ptr <= rx_data[ADDR_W-1:0], then go to WDATA or RDATA.
  - In read mode, also in that same cycle: tx_data <= regs[rx_data], tx_valid <= 1.
- WDATA: each rx_valid writes regs[ptr] <= rx_data with 1-cycle latency. The register value and wr_strobe[ptr] become visible in the cycle after rx_valid. ptr <= ptr+1 modulo NUM_REGS (wraps from NUM_REGS-1 to 0).
- RDATA:
  - On tx_valid & tx_ready: ptr <= ptr+1 (wrapping), tx_data <= regs[ptr+1], tx_valid stays 1. The stream continues back-to-back with no bubble.
  - rx_valid bytes are dummy and ignored.
  - A write to the same register in the same cycle is impossible (single frame at a time).
- DISCARD: all rx_valid ignored until the frame ends.
- Frame end: frame_active=0 in any non-IDLE state -> IDLE on the next cycle, and tx_valid <= 0 in that cycle.
  - Writes already committed remain.
  - rx_valid coincident with frame_active=0 is ignored.
- err_count saturates at 0xFF; it never wraps.
- wr_strobe is 0 in every cycle without a write.
- tx_data holds its last value when tx_valid=0.

Decomposition:
- Shared package nixie_spi_pkg:
  - CMD_WRITE=8'h01, CMD_READ=8'h02.
  - State enum (IDLE, CMD, ADDR, WDATA, RDATA, DISCARD).
- Sub-module spi_reg_bank:
  - NUM_REGS x 8 registers with sync reset, single write port (we, waddr, wdata), two combinational read ports (current ptr and ptr+1), and the flat output plus wr_strobe generation.
- The FSM and err counter stay in spi_cmd_decoder.

Test Plan:
- Write burst: frame [01, 02, AA, BB] -> reg2=0xAA, then reg3=0xBB, each 1 cycle after its rx_valid; wr_strobe=0x04 then 0x08; err_count=0.
- Write wrap: frame [01, 07, 11, 22] with NUM_REGS=8 -> reg7=0x11, reg0=0x22, wr_strobe 0x80 then 0x01.
- Read stream: preload reg5=0x5A, reg6=0x6B; frame [02, 05] with tx_ready held high -> tx_data 0x5A then 0x6B on consecutive cycles, tx_valid continuous; a dummy rx byte changes nothing.
- Rejects: frame [7F, ...] then frame [01, 09, FF] -> no register changes, err_count=2. Repeating rejected frames 300 times -> err_count=0xFF.
- Abort: frame_active drops after [01, 03]; a later rx_valid with 0x44 while frame_active is low -> no write, state=IDLE; the next frame [01, 03, 44] writes reg3=0x44.
- Reset mid-read: rst=1 while tx_valid=1 -> next cycle tx_valid=0, all regs 0x00, err_count=0, state=IDLE.

Source files
------------

// File: rtl/nixie_spi_pkg.sv
// Shared command codes and decoder state encoding for the SPI register interface
// that feeds the nixie display and control logic.
package nixie_spi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        DISCARD
    } state_t;

endpackage

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8-bit register bank: one write port, two combinational read ports
// (raddr and raddr+1, wrapping), flat view of the bank and a one-hot write strobe.
module spi_reg_bank #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [7:0]            rdata_cur,
    output logic [7:0]            rdata_next,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [NUM_REGS-1:0]   wr_strobe
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [7:0]        regs [NUM_REGS];
    logic [ADDR_W-1:0] raddr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
            wr_strobe <= '0;
        end else begin
            wr_strobe <= '0;
            if (we) begin
                regs[waddr]      <= wdata;
                wr_strobe[waddr] <= 1'b1;
            end
        end
    end

    // Address arithmetic is ADDR_W wide, so ptr+1 wraps at NUM_REGS for free.
    assign raddr_next = raddr + ADDR_ONE;
    assign rdata_cur  = regs[raddr];
    assign rdata_next = regs[raddr_next];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses [CMD][ADDR][DATA...] frames from the SPI receive stream into register
// writes and streamed register reads.
//
//   state   | meaning
//   IDLE    | no frame; waits for frame_active
//   CMD     | expects the command byte
//   ADDR    | expects the start address
//   WDATA   | each byte writes regs[ptr], ptr increments
//   RDATA   | streams regs[ptr] out on tx, ptr increments per accept
//   DISCARD | rejected frame; swallow bytes until frame ends
module spi_cmd_decoder
    import nixie_spi_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_active,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [NUM_REGS-1:0]   wr_strobe,
    output logic [7:0]            err_count
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [8:0]        REG_LIMIT = 9'(NUM_REGS);

    state_t            state;
    logic              mode_read;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rdata_cur;
    logic [7:0]        rdata_next;
    logic              wr_en;

    // While the address byte arrives, look up the requested register directly so
    // the first read byte is loaded in the same cycle.
    assign raddr = (state == ADDR) ? rx_data[ADDR_W-1:0] : ptr;
    assign wr_en = (state == WDATA) && frame_active && rx_valid;

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_reg_bank (
        .clk        (clk),
        .rst        (rst),
        .we         (wr_en),
        .waddr      (ptr),
        .wdata      (rx_data),
        .raddr      (raddr),
        .rdata_cur  (rdata_cur),
        .rdata_next (rdata_next),
        .regs_flat  (regs_flat),
        .wr_strobe  (wr_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_read <= 1'b0;
            ptr       <= '0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            err_count <= 8'h00;
        end else if (state == IDLE) begin
            if (frame_active) begin
                state <= CMD;
            end
        end else if (!frame_active) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                CMD: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WRITE) begin
                            mode_read <= 1'b0;
                            state     <= ADDR;
                        end else if (rx_data == CMD_READ) begin
                            mode_read <= 1'b1;
                            state     <= ADDR;
                        end else begin
                            state <= DISCARD;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        if ({1'b0, rx_data} >= REG_LIMIT) begin
                            state <= DISCARD;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end else begin
                            ptr <= rx_data[ADDR_W-1:0];
                            if (mode_read) begin
                                state    <= RDATA;
                                tx_data  <= rdata_cur;
                                tx_valid <= 1'b1;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        ptr <= ptr + ADDR_ONE;
                    end
                end
                RDATA: begin
                    if (tx_valid && tx_ready) begin
                        ptr     <= ptr + ADDR_ONE;
                        tx_data <= rdata_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: frames are described as byte lists, a
// positional model predicts writes/reads, and a monitor checks what the DUT emits.
module tb_spi_cmd_decoder;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_active;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N*8-1:0] regs_flat;
    logic [N-1:0]   wr_strobe;
    logic [7:0]     err_count;

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         tag;
    } wr_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    wr_t        wq[$];
    logic [7:0] rq[$];
    logic [7:0] mregs[N];
    int         merr;
    logic [7:0] fb[$];

    spi_cmd_decoder #(.NUM_REGS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_active (frame_active),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .regs_flat    (regs_flat),
        .wr_strobe    (wr_strobe),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic err_inc();
        if (merr < 255) merr++;
    endtask

    task automatic check_all();
        @(negedge clk);
        for (int i = 0; i < N; i++) check($sformatf("reg%0d", i), regs_flat[i*8 +: 8], mregs[i]);
        check("err_count", err_count, merr);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe and every tx handshake is matched to the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe != '0) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", wr_strobe, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_strobe", wr_strobe, 64'(1) << e.addr);
                    check("wr_data", regs_flat[e.addr*8 +: 8], e.data);
                    check("wr_latency", cyc, e.tag);
                end
            end
            if (tx_valid && tx_ready) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx: got %0h with nothing expected", tx_data);
                end else begin
                    check("tx_data", tx_data, rq.pop_front());
                end
            end
        end
    end

    // Drives the frame held in fb; the model maps byte position to meaning.
    task automatic run_frame(input int n_reads, input bit hold);
        int cmd = -1;
        int base = 0;
        bit addr_ok = 1'b0;
        int pushed = 0;
        int k = 0;
        int budget = 0;
        frame_active = 1'b1;
        tick();
        foreach (fb[i]) begin
            rx_valid = 1'b1;
            rx_data  = fb[i];
            if (i == 0) begin
                cmd = int'(fb[i]);
                if (cmd != 1 && cmd != 2) err_inc();
            end else if (i == 1 && (cmd == 1 || cmd == 2)) begin
                if (int'(fb[i]) >= N) err_inc();
                else begin
                    addr_ok = 1'b1;
                    base    = int'(fb[i]);
                end
            end else if (i >= 2 && cmd == 1 && addr_ok) begin
                int a;
                a = (base + i - 2) % N;
                wq.push_back('{a, fb[i], cyc + 1});
                mregs[a] = fb[i];
            end
            tick();
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        if (cmd == 2 && addr_ok) begin
            for (int j = 0; j < n_reads; j++) rq.push_back(mregs[(base + j) % N]);
            pushed = n_reads;
        end
        if (pushed > 0) begin
            tx_ready = hold ? 1'b1 : 1'($urandom_range(0, 1));
            while (k < pushed && budget < 300) begin
                @(negedge clk);
                if (hold && k > 0) check("tx_valid_cont", tx_valid, 1);
                if (tx_valid && tx_ready) k++;
                @(posedge clk);
                #1;
                budget++;
                rx_valid = ($urandom_range(0, 3) == 0);
                rx_data  = 8'($urandom);
                tx_ready = (k < pushed) ? (hold ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            end
            rx_valid = 1'b0;
            tx_ready = 1'b0;
            if (k < pushed) begin
                total++;
                bad++;
                $display("FAIL tx_timeout: got %0d accepts expected %0d", k, pushed);
                rq.delete();
            end
        end
        frame_active = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        check("tx_valid_end", tx_valid, 0);
        @(posedge clk);
        #1;
        fb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        frame_active = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b0;
        merr = 0;
        for (int i = 0; i < N; i++) mregs[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_err_count", err_count, 0);
        check("rst_regs", regs_flat, 0);
        check("rst_state", dut.state, nixie_spi_pkg::IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        fb = '{8'h01, 8'h02, 8'hAA, 8'hBB};
        run_frame(0, 0);
        check_all();
        fb = '{8'h01, 8'h07, 8'h11, 8'h22};
        run_frame(0, 0);
        check_all();

        fb = '{8'h01, 8'h05, 8'h5A, 8'h6B};
        run_frame(0, 0);
        fb = '{8'h02, 8'h05};
        run_frame(3, 1);
        check_all();

        fb = '{8'h7F, 8'h03, 8'h44};
        run_frame(0, 0);
        fb = '{8'h01, 8'h09, 8'hFF};
        run_frame(0, 0);
        check_all();

        fb = '{8'h01, 8'h03};
        run_frame(0, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        check("abort_state", dut.state, nixie_spi_pkg::IDLE);
        check("abort_reg3", regs_flat[3*8 +: 8], mregs[3]);
        @(posedge clk);
        #1;
        fb = '{8'h01, 8'h03, 8'h44};
        run_frame(0, 0);
        check_all();

        for (int f = 0; f < 60; f++) begin
            logic [7:0] b;
            case ($urandom_range(0, 3))
                0: begin
                    fb.push_back(8'h01);
                    if ($urandom_range(0, 4) != 0) begin
                        fb.push_back(8'($urandom_range(0, 9)));
                        repeat ($urandom_range(0, 5)) fb.push_back(8'($urandom));
                    end
                    run_frame(0, 0);
                end
                1: begin
                    fb.push_back(8'h02);
                    fb.push_back(8'($urandom_range(0, 9)));
                    run_frame($urandom_range(0, 10), 1'($urandom_range(0, 1)));
                end
                2: begin
                    b = 8'($urandom);
                    if (b == 8'h01 || b == 8'h02) b = 8'h55;
                    fb.push_back(b);
                    repeat ($urandom_range(0, 2)) fb.push_back(8'($urandom));
                    run_frame(0, 0);
                end
                default: run_frame(0, 0);
            endcase
        end
        check_all();

        for (int f = 0; f < 300; f++) begin
            if (f % 2 == 1) fb = '{8'h7F};
            else fb = '{8'h01, 8'(8 + $urandom_range(0, 247))};
            run_frame(0, 0);
        end
        check_all();
        check("err_saturated", err_count, 8'hFF);

        frame_active = 1'b1;
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        tick();
        rx_data  = 8'h05;
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_tx_valid", tx_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        frame_active = 1'b0;
        tick();
        rst = 1'b0;
        merr = 0;
        for (int i = 0; i < N; i++) mregs[i] = 8'h00;
        @(negedge clk);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_regs", regs_flat, 0);
        check("midrst_err", err_count, 0);
        check("midrst_state", dut.state, nixie_spi_pkg::IDLE);
        @(posedge clk);
        #1;
        fb = '{8'h01, 8'h06, 8'h9C};
        run_frame(0, 0);
        check_all();
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
